// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//
// Lets two requesters share one add/subtract datapath. One op is in flight
// at a time. In IDLE a round-robin grant picks a requester and its operands
// are latched onto the datapath inputs. The block then waits LAT edges for
// the datapath's registered q, captures q into that requester's result
// register, and pulses its rsp_valid for one cycle.
//
// Parameters
//   N    operand/result width (must match the datapath)
//   LAT  clock edges from a datapath input change until q reflects it (>= 1)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqX_valid/ready                op handshake; ready only in IDLE for the winner
//   reqX_op/cin/a/b                 op (0 add, 1 sub), carry-in, operands
//   rspX_valid                      one-cycle pulse when rspX_data is new
//   rspX_data                       last result for requester X (held)
//   dp_a/dp_b/dp_cin/dp_op          drive the shared datapath inputs
//   dp_q                            datapath result
//   busy                            high whenever an op is in flight

module alu_share_arbiter #(
  parameter int N   = 8,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_op,
  input  logic         req0_cin,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_op,
  input  logic         req1_cin,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp0_valid,
  output logic [N-1:0] rsp0_data,
  output logic         rsp1_valid,
  output logic [N-1:0] rsp1_data,
  output logic [N-1:0] dp_a,
  output logic [N-1:0] dp_b,
  output logic         dp_cin,
  output logic         dp_op,
  input  logic [N-1:0] dp_q,
  output logic         busy
);

  // Wide enough to hold LAT itself.
  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg;
  state_t         state_next;
  logic           last_reg;    // requester granted most recently
  logic           owner_reg;   // requester whose op is in flight
  logic [CW-1:0]  count_reg;
  logic [N-1:0]   dp_a_reg;
  logic [N-1:0]   dp_b_reg;
  logic           dp_cin_reg;
  logic           dp_op_reg;

  logic           grant0;
  logic           grant1;
  logic           accept;
  logic           winner;
  logic           capture;
  logic [N-1:0]   rsp_data [2];
  logic           rsp_valid [2];

  // A lone valid wins outright; on a tie the requester that did not win
  // last time goes first. last_reg resets to 1 so requester 0 wins the
  // first tie.
  assign grant0 = req0_valid & (~req1_valid | last_reg);
  assign grant1 = req1_valid & (~req0_valid | ~last_reg);

  assign req0_ready = (state_reg == IDLE) & grant0;
  assign req1_ready = (state_reg == IDLE) & grant1;

  assign accept  = req0_ready | req1_ready;
  assign winner  = req1_ready;
  // Counter has run down: dp_q now reflects the latched operands.
  assign capture = (state_reg == WAIT) && (count_reg == '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = WAIT;
      WAIT:    if (capture) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      last_reg   <= 1'b1;
      owner_reg  <= 1'b0;
      count_reg  <= '0;
      dp_a_reg   <= '0;
      dp_b_reg   <= '0;
      dp_cin_reg <= 1'b0;
      dp_op_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        // Operands are sampled only here; later input changes are ignored
        // and the datapath inputs stay put until the next accept.
        owner_reg  <= winner;
        last_reg   <= winner;
        count_reg  <= CW'(LAT);
        dp_a_reg   <= winner ? req1_a   : req0_a;
        dp_b_reg   <= winner ? req1_b   : req0_b;
        dp_cin_reg <= winner ? req1_cin : req0_cin;
        dp_op_reg  <= winner ? req1_op  : req0_op;
      end else if ((state_reg == WAIT) && (count_reg != '0)) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Per-requester result register and response pulse.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      logic [N-1:0] data_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
        end else if (capture && (owner_reg == 1'(gi))) begin
          data_reg <= dp_q;
        end
      end

      assign rsp_data[gi]  = data_reg;
      assign rsp_valid[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign rsp0_data  = rsp_data[0];
  assign rsp1_data  = rsp_data[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];

  assign dp_a   = dp_a_reg;
  assign dp_b   = dp_b_reg;
  assign dp_cin = dp_cin_reg;
  assign dp_op  = dp_op_reg;
  assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: a LAT-stage add/subtract datapath model
// is attached to the dp_* ports. A cycle-level scoreboard predicts grants,
// busy, response pulses and held results from the arbitration rules, and
// table vectors, directed sequences and random traffic are run against it.

module tb_alu_share_arbiter;

  localparam int N   = 8;
  localparam int LAT = 1;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_op, req0_cin;
  logic [N-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready, req1_op, req1_cin;
  logic [N-1:0] req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid;
  logic [N-1:0] rsp0_data, rsp1_data;
  logic [N-1:0] dp_a, dp_b, dp_q;
  logic         dp_cin, dp_op;
  logic         busy;

  alu_share_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_cin   (req0_cin),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_cin   (req1_cin),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .dp_a       (dp_a),
    .dp_b       (dp_b),
    .dp_cin     (dp_cin),
    .dp_op      (dp_op),
    .dp_q       (dp_q),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared datapath: result appears LAT edges after its inputs change.
  logic [N-1:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= dp_op ? (dp_a - dp_b - {{(N-1){1'b0}}, dp_cin})
                        : (dp_a + dp_b + {{(N-1){1'b0}}, dp_cin});
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_q = dp_pipe[LAT-1];

  typedef struct {
    logic       v;
    logic       op;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  typedef struct {
    bit         who;
    bit         op;
    bit         cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  int passed;
  int total;
  int cyc;

  // Scoreboard state: phase counts the non-idle cycles left in the current op.
  int         phase;
  bit         m_last;
  bit         m_owner;
  logic [7:0] m_exp;
  logic [7:0] m_rsp [2];
  logic [7:0] m_a, m_b;
  logic       m_cin, m_op;
  int         acc_cyc [$];
  bit         acc_who [$];

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [7:0] ref_alu(input bit op, input bit cin,
                                         input logic [7:0] a, input logic [7:0] b);
    int r;
    r = op ? (int'(a) - int'(b) - int'(cin)) : (int'(a) + int'(b) + int'(cin));
    return 8'(r);
  endfunction

  function automatic req_t mk(input bit v, input bit op, input bit cin,
                              input logic [7:0] a, input logic [7:0] b);
    req_t r;
    r.v = v; r.op = op; r.cin = cin; r.a = a; r.b = b;
    return r;
  endfunction

  task automatic model_reset();
    phase    = 0;
    m_last   = 1'b1;
    m_owner  = 1'b0;
    m_exp    = 8'h00;
    m_rsp[0] = 8'h00;
    m_rsp[1] = 8'h00;
    m_a      = 8'h00;
    m_b      = 8'h00;
    m_cin    = 1'b0;
    m_op     = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_req0_ready"}, req0_ready, 1'b0);
    chk1({tag, "_req1_ready"}, req1_ready, 1'b0);
    chk1({tag, "_busy"},       busy,       1'b0);
    chk1({tag, "_rsp0_valid"}, rsp0_valid, 1'b0);
    chk1({tag, "_rsp1_valid"}, rsp1_valid, 1'b0);
    chk8({tag, "_rsp0_data"},  rsp0_data,  8'h00);
    chk8({tag, "_rsp1_data"},  rsp1_data,  8'h00);
    chk8({tag, "_dp_a"},       dp_a,       8'h00);
    chk8({tag, "_dp_b"},       dp_b,       8'h00);
    chk1({tag, "_dp_cin"},     dp_cin,     1'b0);
    chk1({tag, "_dp_op"},      dp_op,      1'b0);
  endtask

  // One clock cycle: drive at the falling edge, check just after, then
  // advance the scoreboard across the rising edge.
  task automatic step(input req_t r0, input req_t r1);
    bit g0, g1;
    @(negedge clk);
    req0_valid = r0.v; req0_op = r0.op; req0_cin = r0.cin; req0_a = r0.a; req0_b = r0.b;
    req1_valid = r1.v; req1_op = r1.op; req1_cin = r1.cin; req1_a = r1.a; req1_b = r1.b;
    #1;
    g0 = r0.v && (!r1.v || m_last);
    g1 = r1.v && (!r0.v || !m_last);
    chk1("req0_ready", req0_ready, (phase == 0) && g0);
    chk1("req1_ready", req1_ready, (phase == 0) && g1);
    chk1("busy",       busy,       phase > 0);
    chk1("rsp0_valid", rsp0_valid, (phase == 1) && (m_owner == 1'b0));
    chk1("rsp1_valid", rsp1_valid, (phase == 1) && (m_owner == 1'b1));
    chk8("rsp0_data",  rsp0_data,  m_rsp[0]);
    chk8("rsp1_data",  rsp1_data,  m_rsp[1]);
    chk8("dp_a",       dp_a,       m_a);
    chk8("dp_b",       dp_b,       m_b);
    chk1("dp_cin",     dp_cin,     m_cin);
    chk1("dp_op",      dp_op,      m_op);
    if (phase == 1)
      $display("cycle %0d: rsp%0d data=%02h", cyc, m_owner, m_rsp[m_owner]);
    @(posedge clk);
    if (phase > 0) begin
      phase--;
      if (phase == 1) m_rsp[m_owner] = m_exp;
    end else if (g0 || g1) begin
      m_owner = g1;
      m_last  = g1;
      m_a     = g1 ? r1.a   : r0.a;
      m_b     = g1 ? r1.b   : r0.b;
      m_cin   = g1 ? r1.cin : r0.cin;
      m_op    = g1 ? r1.op  : r0.op;
      m_exp   = ref_alu(m_op, m_cin, m_a, m_b);
      phase   = LAT + 2;
      acc_cyc.push_back(cyc);
      acc_who.push_back(g1);
    end
    cyc++;
  endtask

  vec_t vecs [6];
  req_t idle;

  initial begin
    vecs[0] = '{who: 1'b0, op: 1'b0, cin: 1'b0, a: 8'h05, b: 8'h03, exp: 8'h08};
    vecs[1] = '{who: 1'b1, op: 1'b1, cin: 1'b0, a: 8'h03, b: 8'h05, exp: 8'hFE};
    vecs[2] = '{who: 1'b0, op: 1'b0, cin: 1'b0, a: 8'hFF, b: 8'h01, exp: 8'h00};
    vecs[3] = '{who: 1'b1, op: 1'b0, cin: 1'b1, a: 8'h7F, b: 8'h01, exp: 8'h81};
    vecs[4] = '{who: 1'b0, op: 1'b1, cin: 1'b1, a: 8'h00, b: 8'h00, exp: 8'hFF};
    vecs[5] = '{who: 1'b1, op: 1'b1, cin: 1'b0, a: 8'h80, b: 8'h01, exp: 8'h7F};

    passed = 0;
    total  = 0;
    cyc    = 0;
    idle   = mk(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    req0_valid = 0; req0_op = 0; req0_cin = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_cin = 0; req1_a = 0; req1_b = 0;
    model_reset();

    // Reset values.
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors: single requester ops, one at a time.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].who)
        step(idle, mk(1'b1, vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b));
      else
        step(mk(1'b1, vecs[i].op, vecs[i].cin, vecs[i].a, vecs[i].b), idle);
      repeat (LAT + 2) step(idle, idle);
      #1;
      chk8("vec_result", vecs[i].who ? rsp1_data : rsp0_data, vecs[i].exp);
      if (i == 1) chk8("vec_rsp0_hold", rsp0_data, 8'h08);
    end

    // Operands changed after accept must not reach the datapath.
    step(mk(1'b1, 1'b0, 1'b0, 8'h05, 8'h03), idle);
    for (int k = 0; k < LAT + 2; k++) begin
      step(mk(1'b1, 1'b0, 1'b0, 8'h09, 8'h03), idle);
      #1;
      chk8("late_change_dp_a", dp_a, 8'h05);
    end
    chk8("late_change_result", rsp0_data, 8'h08);
    step(idle, idle);

    // Reset in the middle of an op.
    step(idle, mk(1'b1, 1'b1, 1'b0, 8'h20, 8'h01));
    step(idle, idle);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midop_reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (LAT + 3) step(idle, idle);

    // Both requesters held valid: alternate grants, spaced LAT+3 apart.
    acc_cyc.delete();
    acc_who.delete();
    for (int k = 0; k < 4 * (LAT + 3); k++)
      step(mk(1'b1, 1'b0, 1'b0, 8'h10, 8'h20), mk(1'b1, 1'b1, 1'b0, 8'h40, 8'h01));
    chk8("hold_accepts", 8'(acc_who.size()), 8'd4);
    for (int k = 0; k < acc_who.size() && k < 4; k++) begin
      chk1("hold_order", acc_who[k], 1'(k % 2));
      if (k > 0) chk8("hold_spacing", 8'(acc_cyc[k] - acc_cyc[k-1]), 8'(LAT + 3));
    end
    repeat (LAT + 3) step(idle, idle);

    // Random traffic against the scoreboard.
    for (int k = 0; k < 300; k++) begin
      req_t r0, r1;
      r0 = mk($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom), 8'($urandom));
      r1 = mk($urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom), 8'($urandom));
      step(r0, r1);
    end
    repeat (LAT + 3) step(idle, idle);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
